sram_responder: RTL
===================

// Module: sram_responder
// PURPOSE
//  Responder (memory) end of the CE/UB/LB/OE/WE/ADDR/Data SRAM bus that the SLC-3 drives via Mem2IO.
//  On-chip, byte-laned word memory with programmable read latency.
//  Also has a valid/ready preload port so a loader can fill program memory before Run.
//  Used as the on-chip substitute for the external 1Mx16 SRAM and as the memory model in CPU benches.
// PARAMETERS
//  ADDR_W  10  implemented word-address bits; depth = 2**ADDR_W words
//  RD_LAT  2   cycles from read request sampled to Data_oe high; legal 1..4
// PORTS
//  Clk        in   1       system clock, all state on rising edge
//  Reset      in   1       asynchronous, active-low reset
//  CE         in   1       chip enable, active-low
//  UB         in   1       upper byte [15:8] enable, active-low
//  LB         in   1       lower byte [7:0] enable, active-low
//  OE         in   1       output enable (read), active-low
//  WE         in   1       write enable, active-low
//  ADDR       in   20      word address from initiator
//  Data_in    in   16      write data from bus (tristate read side)
//  Data_out   out  16      read data to bus
//  Data_oe    out  1       high = responder drives Data_out onto bus
//  Ld_valid   in   1       preload word offered
//  Ld_ready   out  1       preload word can be accepted this cycle
//  Ld_addr    in   ADDR_W  preload word address
//  Ld_data    in   16      preload word
//  Oob        out  1       one-cycle pulse: access with ADDR[19:ADDR_W] != 0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - Data_out=0, Data_oe=0, Oob=0, FSM=IDLE, latency counter=0, pending write discarded.
//   - Ld_ready=0 while Reset low.
//   - Memory contents are not cleared.
//  Bus request classes, sampled each edge with CE low:
//   - write: WE=0. Write wins if OE also low; Data_oe is then forced 0.
//   - read: WE=1 and OE=0.
//   - CE high: no request.
//  FSM states: IDLE, RD_WAIT, RD_DRIVE, WR_HOLD.
//   IDLE
//    - read -> RD_WAIT: issue synchronous array read, capture ADDR, counter=RD_LAT-1.
//    - write -> WR_HOLD.
//    - otherwise stay.
//   RD_WAIT
//    - counter==0 -> RD_DRIVE: Data_out=lane-masked word, Data_oe=1; else decrement.
//    - read abandoned (CE or OE high) -> IDLE.
//    - write seen -> WR_HOLD.
//   RD_DRIVE
//    - Data_oe stays 1 while read persists with unchanged ADDR.
//    - ADDR change -> RD_WAIT with the new read (Data_oe=0 that cycle).
//    - read ends -> IDLE; Data_oe drops in that same cycle.
//    - write seen -> WR_HOLD.
//   WR_HOLD
//    - Each cycle WE=0 and CE=0: latch ADDR, Data_in, UB, LB (last value wins).
//    - First cycle WE or CE high: commit latched word to enabled lanes; go IDLE, or to RD_WAIT if that cycle is a read.
//    - Reset while in WR_HOLD: nothing is written.
//  Byte lanes:
//   - Read: disabled lane returns 8'h00.
//   - Write: only lanes with UB/LB low are updated. UB=LB=1 is a no-op write.
//  Out-of-range (ADDR[19:ADDR_W] != 0):
//   - Read returns 16'h0000 after normal latency.
//   - Write is discarded.
//   - Oob pulses once at request start (entry to RD_WAIT or WR_HOLD).
//  Preload:
//   - Ld_ready=1 only when FSM=IDLE and CE=1.
//   - Transfer on Ld_valid&Ld_ready writes the full word; at most one per cycle.
//   - Bus request in the same cycle wins: Ld_ready is 0 because CE is low.
//  Address wrap: none; ADDR_W bits index memory directly. Ld_addr covers the full depth.
// TESTING
//  1. Reset=0 mid RD_DRIVE -> Data_oe=0, Data_out=0 immediately (async).
//     After release, Ld_ready=1 the first cycle CE=1.
//  2. Preload 0x0000<=16'h1234 via Ld, then CE=0 OE=0 WE=1 ADDR=0, RD_LAT=2
//     -> Data_oe rises exactly 2 cycles after the request edge, Data_out=16'h1234.
//  3. Write 16'hABCD at 0x0005 with UB=1 LB=0, then read it back
//     -> 16'h00CD (upper lane was 0, not written).
//     Same read with UB=0 LB=1 -> 16'h0000.
//  4. Hold WE=0 over three cycles with Data_in 1,2,3 at 0x0007
//     -> only 16'h0003 stored; Reset asserted instead of WE release -> location unchanged.
//  5. CE=0 OE=0 WE=0 together -> Data_oe stays 0, write committed.
//     ADDR=20'h10000 read -> Oob single pulse, Data_out=0.
//  6. Read in RD_DRIVE, ADDR changes 0x2->0x3
//     -> Data_oe low for RD_LAT cycles, then mem[3] driven.
//     Ld_valid held during the CE=0 phase -> no transfer until CE=1.

Source files
------------

// File: rtl/sram_responder.sv
// On-chip byte-laned word memory answering the CE/UB/LB/OE/WE SRAM bus,
// with programmable read latency and a valid/ready preload port.
module sram_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CE,
    input  logic              UB,
    input  logic              LB,
    input  logic              OE,
    input  logic              WE,
    input  logic [19:0]       ADDR,
    input  logic [15:0]       Data_in,
    output logic [15:0]       Data_out,
    output logic              Data_oe,
    input  logic              Ld_valid,
    output logic              Ld_ready,
    input  logic [ADDR_W-1:0] Ld_addr,
    input  logic [15:0]       Ld_data,
    output logic              Oob
);

    // state    | meaning
    // IDLE     | no bus request in progress, preload allowed when CE=1
    // RD_WAIT  | read accepted, counting down the latency
    // RD_DRIVE | read data valid, driving the bus while the read persists
    // WR_HOLD  | write in progress, latching the last bus value each cycle
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [15:0] mem [2**ADDR_W];
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic        ub_q, lb_q;
    logic [1:0]  cnt_q;
    logic        rd_req, wr_req, addr_oob, addr_q_oob, addr_same;
    logic        start_rd, start_wr, latch_wr, commit, drive, cnt_dec;

    assign wr_req     = !CE && !WE;
    assign rd_req     = !CE && WE && !OE;
    assign addr_oob   = ADDR[19:ADDR_W] != '0;
    assign addr_q_oob = addr_q[19:ADDR_W] != '0;
    assign addr_same  = ADDR == addr_q;

    // Output enable follows the live bus so it drops the same cycle the read ends or moves.
    assign Data_oe  = (state_q == RD_DRIVE) && rd_req && addr_same;
    assign Ld_ready = Reset && (state_q == IDLE) && CE;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_rd = 1'b0;
        start_wr = 1'b0;
        latch_wr = 1'b0;
        commit   = 1'b0;
        drive    = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d  = WR_HOLD;
                    start_wr = 1'b1;
                end else if (rd_req) begin
                    state_d  = RD_WAIT;
                    start_rd = 1'b1;
                end
            end
            RD_WAIT: begin
                if (wr_req) begin
                    state_d  = WR_HOLD;
                    start_wr = 1'b1;
                end else if (!rd_req) begin
                    state_d = IDLE;
                end else if (!addr_same) begin
                    start_rd = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = RD_DRIVE;
                    drive   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_DRIVE: begin
                if (wr_req) begin
                    state_d  = WR_HOLD;
                    start_wr = 1'b1;
                end else if (!rd_req) begin
                    state_d = IDLE;
                end else if (!addr_same) begin
                    state_d  = RD_WAIT;
                    start_rd = 1'b1;
                end
            end
            WR_HOLD: begin
                if (wr_req) begin
                    latch_wr = 1'b1;
                end else begin
                    commit = 1'b1;
                    if (rd_req) begin
                        state_d  = RD_WAIT;
                        start_rd = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            ub_q     <= 1'b1;
            lb_q     <= 1'b1;
            cnt_q    <= '0;
            Data_out <= '0;
            Oob      <= 1'b0;
        end else begin
            Oob <= (start_rd || start_wr) && addr_oob;
            if (start_rd) begin
                addr_q <= ADDR;
                cnt_q  <= LAT_INIT;
            end
            if (start_wr || latch_wr) begin
                addr_q  <= ADDR;
                wdata_q <= Data_in;
                ub_q    <= UB;
                lb_q    <= LB;
            end
            if (cnt_dec) cnt_q <= cnt_q - 2'd1;
            if (drive) begin
                if (addr_q_oob) begin
                    Data_out <= '0;
                end else begin
                    Data_out[15:8] <= UB ? 8'h00 : mem[addr_q[ADDR_W-1:0]][15:8];
                    Data_out[7:0]  <= LB ? 8'h00 : mem[addr_q[ADDR_W-1:0]][7:0];
                end
            end
        end
    end

    // Memory is deliberately outside reset; commit and preload are exclusive by state.
    always_ff @(posedge Clk) begin
        if (commit && !addr_q_oob) begin
            if (!ub_q) mem[addr_q[ADDR_W-1:0]][15:8] <= wdata_q[15:8];
            if (!lb_q) mem[addr_q[ADDR_W-1:0]][7:0]  <= wdata_q[7:0];
        end else if (Ld_valid && Ld_ready) begin
            mem[Ld_addr] <= Ld_data;
        end
    end

endmodule
